// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back path: widths, register count, requester indices.
// Helper for wrapping round-robin pointers.
package regfile_wb_arbiter_pkg;

  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_NUM_REQ = 3;
  localparam int NUM_REGS    = 32;

  localparam int REQ_ALU     = 0;
  localparam int REQ_LOAD    = 1;
  localparam int REQ_MULDIV  = 2;

  function automatic int rr_next(input int g, input int n);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above ptr_i, wrapping.
// Purely combinational, zero latency; grants only asserted requests, so no grant without a request.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic             gnt_vld_o
);

  logic [N-1:0] gnt_hi;
  logic [N-1:0] gnt_lo;
  logic         hit_hi;
  logic         hit_lo;

  // Two passes over the same vector: indices at/above the pointer win over the wrapped ones.
  always_comb begin
    gnt_hi = '0;
    gnt_lo = '0;
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        if (i >= int'(ptr_i)) begin
          if (!hit_hi) begin
            gnt_hi[i] = 1'b1;
            hit_hi    = 1'b1;
          end
        end else if (!hit_lo) begin
          gnt_lo[i] = 1'b1;
          hit_lo    = 1'b1;
        end
      end
    end
  end

  assign gnt_o     = hit_hi ? gnt_hi : gnt_lo;
  assign gnt_vld_o = hit_hi | hit_lo;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter + pending-write scoreboard for the single register-file write port.
// Grant is combinational, rf_* outputs are 1 cycle after the grant; the port never backpressures.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_reg_write,
  output logic [ADDR_W-1:0]         rf_write_register,
  output logic [DATA_W-1:0]         rf_write_data,
  input  logic                      sb_set_valid,
  input  logic [ADDR_W-1:0]         sb_set_addr,
  output logic [NUM_REGS-1:0]       sb_busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]  gnt;
  logic                gnt_vld;
  logic [PTR_W-1:0]    gnt_idx;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_vld_o (gnt_vld)
  );

  // Ready is forced low during reset so nothing is consumed while the write is being dropped.
  assign req_ready = rst_n ? gnt : '0;

  always_comb begin
    gnt_idx  = '0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PTR_W'(i);
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d   = gnt_vld ? PTR_W'(rr_next(int'(gnt_idx), NUM_REQ)) : ptr_q;
    we_d    = gnt_vld && (win_addr != '0);
    waddr_d = gnt_vld ? win_addr : waddr_q;
    wdata_d = gnt_vld ? win_data : wdata_q;
  end

  // Clear before set: a reservation on the same edge belongs to a newer producer and must survive.
  always_comb begin
    busy_d = busy_q;
    if (we_d) begin
      busy_d[win_addr] = 1'b0;
    end
    if (sb_set_valid && (sb_set_addr != '0)) begin
      busy_d[sb_set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_reg_write      = we_q;
  assign rf_write_register = waddr_q;
  assign rf_write_data     = wdata_q;
  assign sb_busy           = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: reference model of the round-robin/scoreboard rules checked every
// negedge, plus directed vectors with literal expectations.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [14:0] req_addr = '0;
  logic [95:0] req_data = '0;
  logic [2:0]  req_ready;
  logic        rf_reg_write;
  logic [4:0]  rf_write_register;
  logic [31:0] rf_write_data;
  logic        sb_set_valid = 1'b0;
  logic [4:0]  sb_set_addr = '0;
  logic [31:0] sb_busy;

  int total = 0;
  int bad = 0;

  regfile_wb_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_addr          (req_addr),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .rf_reg_write      (rf_reg_write),
    .rf_write_register (rf_write_register),
    .rf_write_data     (rf_write_data),
    .sb_set_valid      (sb_set_valid),
    .sb_set_addr       (sb_set_addr),
    .sb_busy           (sb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state is what the register-file port and busy table must show.
  int          m_ptr = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_busy = '0;

  function automatic int m_winner();
    for (int k = 0; k < 3; k++) begin
      if (req_valid[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
    end
    return -1;
  endfunction

  int          mw;
  logic [4:0]  ma;
  logic [31:0] nb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_busy = '0;
    end else begin
      mw = m_winner();
      nb = m_busy;
      if (mw >= 0) begin
        ma     = req_addr[mw*5 +: 5];
        m_we   = (ma != 0);
        m_addr = ma;
        m_data = req_data[mw*32 +: 32];
        if (ma != 0) nb[ma] = 1'b0;
        m_ptr  = (mw + 1) % 3;
      end else begin
        m_we = 1'b0;
      end
      if (sb_set_valid && sb_set_addr != 0) nb[sb_set_addr] = 1'b1;
      m_busy = nb;
    end
  end

  int          cw;
  logic [2:0]  exp_rdy;

  always @(negedge clk) begin
    cw = m_winner();
    exp_rdy = '0;
    if (rst_n && cw >= 0) exp_rdy[cw] = 1'b1;
    check("cyc_ready", {29'd0, req_ready}, {29'd0, exp_rdy});
    check("cyc_we", {31'd0, rf_reg_write}, {31'd0, m_we});
    check("cyc_addr", {27'd0, rf_write_register}, {27'd0, m_addr});
    check("cyc_data", rf_write_data, m_data);
    check("cyc_busy", sb_busy, m_busy);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]        = v;
    req_addr[i*5 +: 5]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  logic [2:0] seen[$];
  logic [2:0] exp_seq [6];

  initial begin
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    #1 rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // 1: idle after reset
    for (int c = 0; c < 5; c++) begin
      #2;
      check("t1_ready", {29'd0, req_ready}, 32'd0);
      check("t1_we", {31'd0, rf_reg_write}, 32'd0);
      check("t1_busy", sb_busy, 32'd0);
      step();
    end

    // 2: single ALU write
    drive(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #2 check("t2_ready", {29'd0, req_ready}, 32'b001);
    step();
    drive(0, 1'b0, 5'd0, 32'd0);
    check("t2_we", {31'd0, rf_reg_write}, 32'd1);
    check("t2_addr", {27'd0, rf_write_register}, 32'd5);
    check("t2_data", rf_write_data, 32'hDEADBEEF);

    // 5: address 0 consumed without write or scoreboard effect (also moves pointer back to 0)
    drive(2, 1'b1, 5'd0, 32'h55);
    sb_set_valid = 1'b1; sb_set_addr = 5'd0;
    #2 check("t5_ready", {29'd0, req_ready}, 32'b100);
    step();
    drive(2, 1'b0, 5'd0, 32'd0);
    sb_set_valid = 1'b0;
    check("t5_we", {31'd0, rf_reg_write}, 32'd0);
    check("t5_busy0", {31'd0, sb_busy[0]}, 32'd0);

    // 3: all three requesters continuously valid
    drive(0, 1'b1, 5'd1, 32'h101);
    drive(1, 1'b1, 5'd2, 32'h102);
    drive(2, 1'b1, 5'd3, 32'h103);
    for (int c = 0; c < 6; c++) begin
      #2 seen.push_back(req_ready);
      step();
      check("t3_we", {31'd0, rf_reg_write}, 32'd1);
    end
    req_valid = '0;
    for (int c = 0; c < 6; c++) check("t3_order", {29'd0, seen[c]}, {29'd0, exp_seq[c]});

    // 4: scoreboard set, clear by write-back, and set winning over a same-edge clear
    sb_set_valid = 1'b1; sb_set_addr = 5'd7;
    step();
    sb_set_valid = 1'b0;
    check("t4_set", {31'd0, sb_busy[7]}, 32'd1);
    drive(1, 1'b1, 5'd7, 32'h77);
    step();
    drive(1, 1'b0, 5'd0, 32'd0);
    check("t4_clr_we", {31'd0, rf_reg_write}, 32'd1);
    check("t4_clr", {31'd0, sb_busy[7]}, 32'd0);
    drive(1, 1'b1, 5'd7, 32'h78);
    sb_set_valid = 1'b1; sb_set_addr = 5'd7;
    step();
    drive(1, 1'b0, 5'd0, 32'd0);
    sb_set_valid = 1'b0;
    check("t4_setwins", {31'd0, sb_busy[7]}, 32'd1);
    check("t4_setwins_data", rf_write_data, 32'h78);

    // same destination from two requesters: pointer is at 2, so requester 2 goes first
    drive(0, 1'b1, 5'd9, 32'hA0);
    drive(2, 1'b1, 5'd9, 32'hA2);
    #2 check("dup_ready0", {29'd0, req_ready}, 32'b100);
    step();
    drive(2, 1'b0, 5'd0, 32'd0);
    check("dup_data0", rf_write_data, 32'hA2);
    #2 check("dup_ready1", {29'd0, req_ready}, 32'b001);
    step();
    drive(0, 1'b0, 5'd0, 32'd0);
    check("dup_data1", rf_write_data, 32'hA0);

    // 6: reset mid-operation with pointer at 1 and a grant pending
    sb_set_valid = 1'b1; sb_set_addr = 5'd3;
    step();
    sb_set_valid = 1'b0;
    check("t6_busy3", {31'd0, sb_busy[3]}, 32'd1);
    drive(1, 1'b1, 5'd3, 32'h33);
    #2 check("t6_pre_ready", {29'd0, req_ready}, 32'b010);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", {29'd0, req_ready}, 32'd0);
    check("t6_rst_we", {31'd0, rf_reg_write}, 32'd0);
    check("t6_rst_addr", {27'd0, rf_write_register}, 32'd0);
    check("t6_rst_data", rf_write_data, 32'd0);
    check("t6_rst_busy", sb_busy, 32'd0);
    drive(1, 1'b0, 5'd0, 32'd0);
    step();
    rst_n = 1'b1;
    drive(0, 1'b1, 5'd4, 32'h44);
    drive(1, 1'b1, 5'd3, 32'h33);
    #2 check("t6_ptr0", {29'd0, req_ready}, 32'b001);
    step();
    drive(0, 1'b0, 5'd0, 32'd0);
    check("t6_post_addr", {27'd0, rf_write_register}, 32'd4);
    step();
    drive(1, 1'b0, 5'd0, 32'd0);
    check("t6_post_addr2", {27'd0, rf_write_register}, 32'd3);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back arbiter and pending-write scoreboard for the 32x32 register file. Several producers (ALU result, load data, multi-cycle mul/div unit) each request the register file's single write port through valid/ready handshakes. A round-robin arbiter grants one producer per cycle and drives the port (reg_write, write_register, write_data) from a registered output stage. A busy-bit scoreboard marks destination registers that still have a write in flight, so issue logic can stall on read-after-write hazards.

Parameters:
NUM_REQ, 3, number of write-back requesters (index 0 = ALU, 1 = load, 2 = mul/div)
DATA_W, 32, write data width
ADDR_W, 5, register address width (32 registers)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ*ADDR_W  packed destination addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant, combinational; asserted only with the matching req_valid
rf_reg_write  output  1  register-file write enable (registered)
rf_write_register  output  ADDR_W  register-file write address (registered)
rf_write_data  output  DATA_W  register-file write data (registered)
sb_set_valid  input  1  issue logic reserves a destination register
sb_set_addr  input  ADDR_W  register being reserved
sb_busy  output  32  bit r = 1 while register r has a pending write

Behaviour:
- Reset (async assert, sync deassert handled upstream): rf_reg_write=0, rf_write_register=0, rf_write_data=0, sb_busy=0, round-robin pointer=0. req_ready=0 while rst_n=0.
- Handshake: a requester holds valid, addr and data stable until it sees ready=1 in the same cycle. A transfer happens when valid and ready are both 1 at a rising edge. Ready never asserts without valid.
- Arbitration: round-robin starting at the pointer. The first valid index at or above the pointer (wrapping) wins. Exactly one grant per cycle, or none if no requester is valid.
- Pointer update: after a grant to index g, the pointer becomes (g+1) mod NUM_REQ. With no grant it holds its value.
- Output stage latency is 1 cycle. At the edge where a grant occurs, the rf_* outputs load the winner's address and data, and rf_reg_write=1 unless the address is 0.
- With no grant, rf_reg_write=0 in the next cycle. rf_write_register and rf_write_data hold their last values.
- Address 0: the request is granted and consumed (ready=1) but produces rf_reg_write=0. It has no scoreboard effect.
- There is no backpressure from the register file, which accepts a write every cycle. Sustained throughput is one write per cycle.
- Same destination from two requesters in one cycle: only the granted one is written. The other waits and writes in a later cycle.
- Scoreboard set: when sb_set_valid=1 and sb_set_addr!=0, busy[sb_set_addr] becomes 1 at the edge.
- Scoreboard clear: busy[a] is cleared at the edge where a grant with address a (a!=0) is captured, i.e. the same edge that loads rf_*.
- Set and clear of the same address at the same edge: set wins (a newer producer is in flight), so busy stays 1.
- busy[0] is constant 0. Clearing a register that is not busy is harmless.
- Reset mid-transfer drops the in-flight write (rf_reg_write=0) and clears every busy bit. Requesters re-present after reset.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, NUM_REGS=32, and requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_MULDIV=2.
- One sub-module: rr_arbiter (parameter N; inputs req[N] and the pointer; outputs a one-hot grant and a grant-valid flag). It is reusable for other shared resources.
- The scoreboard and the output register stay in this top module.

Test Plan:
1. Reset release, all req_valid=0 -> rf_reg_write=0, sb_busy=0, req_ready=0 for 5 cycles.
2. Single write: req 0 valid, addr=5, data=0xDEADBEEF -> req_ready=001 the same cycle. Next cycle: rf_reg_write=1, rf_write_register=5, rf_write_data=0xDEADBEEF.
3. All three requesters valid continuously (addrs 1/2/3) -> grants in order 0,1,2,0,… with one rf write per cycle. No requester waits more than 2 cycles.
4. Scoreboard: sb_set addr=7 -> sb_busy[7]=1. Then req 1 writes addr 7 -> busy[7]=0 at the edge that asserts rf_reg_write. Repeat with a simultaneous sb_set addr=7 on that edge -> busy[7] stays 1.
5. Address 0: req 2 valid, addr=0 -> req_ready=1, rf_reg_write=0 next cycle. sb_set addr=0 -> sb_busy[0] stays 0.
6. Reset mid-operation: busy[3]=1 and a grant pending, assert rst_n=0 asynchronously -> all outputs 0 immediately, pointer back to 0 after release.
